// File: rtl/hispi_tx_packetizer.sv
// hispi_tx_packetizer
// Reads 32-bit pixel beats ({pix1, pix0}, 12 valid bits per half) from an
// AXI-Stream source. Emits a 4-lane x 12-bit HiSPi Packetized-SP word stream
// framed with SOF/SOL/EOL/EOF sync codes and blanking. The stream feeds a
// serializer and advances one word per tx_ce strobe.
//
// Ports
//   clk, aresetn        clock, asynchronous active-low reset
//   tx_ce               serializer word strobe
//   start               frame request (sampled only when idle)
//   line_words          words per line (4 pixels per word)
//   num_lines           lines per frame
//   hblank / vblank     idle words after each EOL / after EOF
//   s_axis_*            pixel beat stream (tlast ignored)
//   lane_data           {lane3, lane2, lane1, lane0}
//   lane_sync           lane_data holds a sync word
//   busy / done         frame in progress / one-cycle end-of-frame pulse
//   frame_count         completed frames (wraps)
//   underrun_count      words emitted without pixel data (saturates)
module hispi_tx_packetizer #(
    parameter logic [11:0] IDLE_WORD = 12'h000,
    parameter logic [11:0] CODE_SOF  = 12'h003,
    parameter logic [11:0] CODE_SOL  = 12'h001,
    parameter logic [11:0] CODE_EOF  = 12'h007,
    parameter logic [11:0] CODE_EOL  = 12'h005
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        tx_ce,
    input  logic        start,
    input  logic [11:0] line_words,
    input  logic [11:0] num_lines,
    input  logic [7:0]  hblank,
    input  logic [15:0] vblank,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [47:0] lane_data,
    output logic        lane_sync,
    output logic        busy,
    output logic        done,
    output logic [7:0]  frame_count,
    output logic [7:0]  underrun_count
);

    localparam int unsigned LANE_W   = 12;
    localparam int unsigned BEAT_W   = 2 * LANE_W;
    localparam int unsigned BUDGET_W = 25;
    localparam int unsigned CNT_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC_S,
        ST_ACTIVE,
        ST_SYNC_E,
        ST_HBLANK,
        ST_VBLANK
    } state_t;

    state_t                state_q, state_d;
    logic [11:0]           lw_q, lw_d;
    logic [11:0]           nl_q, nl_d;
    logic [7:0]            hb_q, hb_d;
    logic [15:0]           vb_q, vb_d;
    logic [BUDGET_W-1:0]   budget_q, budget_d;
    logic [BEAT_W-1:0]     beat0_q, beat0_d;
    logic [BEAT_W-1:0]     beat1_q, beat1_d;
    logic [1:0]            held_q, held_d;
    logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
    logic [11:0]           line_cnt_q, line_cnt_d;
    logic [4*LANE_W-1:0]   lane_data_q, lane_data_d;
    logic                  lane_sync_q, lane_sync_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [7:0]            frame_count_q, frame_count_d;
    logic [7:0]            underrun_count_q, underrun_count_d;

    logic                  tready_c;
    logic                  beat_hs_c;
    logic [BEAT_W-1:0]     beat_in_c;
    logic                  consume_c;
    logic                  underrun_c;
    logic                  frame_end_c;
    logic                  last_line_c;
    logic [1:0]            held_v;
    logic                  unused_inputs;

    // Only the low 12 bits of each pixel half carry data; tlast is not used.
    assign unused_inputs = &{1'b0, s_axis_tlast, s_axis_tdata[31:28], s_axis_tdata[15:12]};

    function automatic logic [11:0] sync_word(input logic [1:0] idx, input logic [11:0] code);
        case (idx)
            2'd0:    return 12'hFFF;
            2'd3:    return code;
            default: return 12'h000;
        endcase
    endfunction

    function automatic logic [4*LANE_W-1:0] all_lanes(input logic [11:0] w);
        return {4{w}};
    endfunction

    // Prefetch into the two-beat pair while budget remains.
    assign tready_c    = busy_q && (budget_q != '0) && (held_q != 2'd2);
    assign beat_hs_c   = tready_c && s_axis_tvalid;
    assign beat_in_c   = {s_axis_tdata[27:16], s_axis_tdata[11:0]};
    assign last_line_c = (line_cnt_q == (nl_q - 12'd1));

    // Next-state, framing and pair-buffer logic.
    always_comb begin
        state_d          = state_q;
        lw_d             = lw_q;
        nl_d             = nl_q;
        hb_d             = hb_q;
        vb_d             = vb_q;
        budget_d         = budget_q;
        beat0_d          = beat0_q;
        beat1_d          = beat1_q;
        held_d           = held_q;
        word_cnt_d       = word_cnt_q;
        line_cnt_d       = line_cnt_q;
        lane_data_d      = lane_data_q;
        lane_sync_d      = lane_sync_q;
        busy_d           = busy_q;
        done_d           = 1'b0;
        frame_count_d    = frame_count_q;
        underrun_count_d = underrun_count_q;
        consume_c        = 1'b0;
        underrun_c       = 1'b0;
        frame_end_c      = 1'b0;
        held_v           = held_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lw_d             = line_words;
                    nl_d             = num_lines;
                    hb_d             = hblank;
                    vb_d             = vblank;
                    underrun_count_d = 8'd0;
                    if ((line_words == 12'd0) || (num_lines == 12'd0)) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d     = 1'b1;
                        budget_d   = {24'(line_words) * 24'(num_lines), 1'b0};
                        word_cnt_d = '0;
                        line_cnt_d = '0;
                        state_d    = ST_SYNC_S;
                    end
                end
            end

            ST_SYNC_S: begin
                if (tx_ce) begin
                    lane_data_d = all_lanes(sync_word(word_cnt_q[1:0],
                                            (line_cnt_q == 12'd0) ? CODE_SOF : CODE_SOL));
                    lane_sync_d = 1'b1;
                    if (word_cnt_q == CNT_W'(3)) begin
                        word_cnt_d = '0;
                        state_d    = ST_ACTIVE;
                    end else begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_ACTIVE: begin
                if (tx_ce) begin
                    lane_sync_d = 1'b0;
                    if (held_q == 2'd2) begin
                        lane_data_d = {beat1_q, beat0_q};
                        consume_c   = 1'b1;
                    end else begin
                        // Keep the line length; the missing pixels become zeros.
                        lane_data_d = all_lanes(12'h000);
                        underrun_c  = 1'b1;
                        if (underrun_count_q != 8'hFF) begin
                            underrun_count_d = underrun_count_q + 8'd1;
                        end
                    end
                    if (word_cnt_q == CNT_W'(lw_q - 12'd1)) begin
                        word_cnt_d = '0;
                        state_d    = ST_SYNC_E;
                    end else begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_SYNC_E: begin
                if (tx_ce) begin
                    lane_data_d = all_lanes(sync_word(word_cnt_q[1:0],
                                            last_line_c ? CODE_EOF : CODE_EOL));
                    lane_sync_d = 1'b1;
                    if (word_cnt_q == CNT_W'(3)) begin
                        word_cnt_d = '0;
                        if (last_line_c) begin
                            if (vb_q == 16'd0) begin
                                frame_end_c = 1'b1;
                            end else begin
                                state_d = ST_VBLANK;
                            end
                        end else if (hb_q == 8'd0) begin
                            line_cnt_d = line_cnt_q + 12'd1;
                            state_d    = ST_SYNC_S;
                        end else begin
                            state_d = ST_HBLANK;
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_HBLANK: begin
                if (tx_ce) begin
                    lane_data_d = all_lanes(IDLE_WORD);
                    lane_sync_d = 1'b0;
                    if (word_cnt_q == CNT_W'(hb_q - 8'd1)) begin
                        word_cnt_d = '0;
                        line_cnt_d = line_cnt_q + 12'd1;
                        state_d    = ST_SYNC_S;
                    end else begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_VBLANK: begin
                if (tx_ce) begin
                    lane_data_d = all_lanes(IDLE_WORD);
                    lane_sync_d = 1'b0;
                    if (word_cnt_q == (vb_q - 16'd1)) begin
                        word_cnt_d  = '0;
                        frame_end_c = 1'b1;
                    end else begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (frame_end_c) begin
            state_d       = ST_IDLE;
            busy_d        = 1'b0;
            done_d        = 1'b1;
            frame_count_d = frame_count_q + 8'd1;
        end

        // On underrun the pair is dropped and the budget gives up exactly the
        // beats that pair still lacked, so the frame drains with no leftovers.
        // A beat arriving in that same cycle fills one of those missing slots.
        if (underrun_c) begin
            held_d   = 2'd0;
            budget_d = budget_q - BUDGET_W'(2'd2 - held_q);
        end else begin
            held_v = consume_c ? 2'd0 : held_q;
            if (beat_hs_c) begin
                if (held_v == 2'd0) begin
                    beat0_d = beat_in_c;
                end else begin
                    beat1_d = beat_in_c;
                end
                held_v   = held_v + 2'd1;
                budget_d = budget_q - BUDGET_W'(1);
            end
            held_d = held_v;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q          <= ST_IDLE;
            lw_q             <= '0;
            nl_q             <= '0;
            hb_q             <= '0;
            vb_q             <= '0;
            budget_q         <= '0;
            beat0_q          <= '0;
            beat1_q          <= '0;
            held_q           <= '0;
            word_cnt_q       <= '0;
            line_cnt_q       <= '0;
            lane_data_q      <= {4{IDLE_WORD}};
            lane_sync_q      <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            frame_count_q    <= '0;
            underrun_count_q <= '0;
        end else begin
            state_q          <= state_d;
            lw_q             <= lw_d;
            nl_q             <= nl_d;
            hb_q             <= hb_d;
            vb_q             <= vb_d;
            budget_q         <= budget_d;
            beat0_q          <= beat0_d;
            beat1_q          <= beat1_d;
            held_q           <= held_d;
            word_cnt_q       <= word_cnt_d;
            line_cnt_q       <= line_cnt_d;
            lane_data_q      <= lane_data_d;
            lane_sync_q      <= lane_sync_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            frame_count_q    <= frame_count_d;
            underrun_count_q <= underrun_count_d;
        end
    end

    assign s_axis_tready  = tready_c;
    assign lane_data      = lane_data_q;
    assign lane_sync      = lane_sync_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign frame_count    = frame_count_q;
    assign underrun_count = underrun_count_q;

endmodule

// File: tb/tb_hispi_tx_packetizer.sv
// Bench for hispi_tx_packetizer: expected lane words for each frame are queued
// when the frame is launched and popped on every tx_ce edge of the DUT.
module tb_hispi_tx_packetizer;

    localparam int LW = 2;
    localparam int NL = 2;
    localparam int HB = 3;
    localparam int VB = 2;
    localparam int NBEATS = 2 * LW * NL;

    typedef struct packed {
        logic [47:0] data;
        logic        sync;
    } word_t;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        tx_ce;
    logic        start;
    logic [11:0] line_words;
    logic [11:0] num_lines;
    logic [7:0]  hblank;
    logic [15:0] vblank;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [47:0] lane_data;
    logic        lane_sync;
    logic        busy;
    logic        done;
    logic [7:0]  frame_count;
    logic [7:0]  underrun_count;

    word_t       exp_q[$];
    logic [31:0] beat_q[$];
    logic [31:0] frame_beats[NBEATS];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          accepted = 0;
    logic        tready_seen = 1'b0;
    logic        mon_en = 1'b0;
    logic        has_last = 1'b0;
    logic        ce_s;
    word_t       last_exp;
    word_t       cur;

    hispi_tx_packetizer dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .tx_ce          (tx_ce),
        .start          (start),
        .line_words     (line_words),
        .num_lines      (num_lines),
        .hblank         (hblank),
        .vblank         (vblank),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .lane_data      (lane_data),
        .lane_sync      (lane_sync),
        .busy           (busy),
        .done           (done),
        .frame_count    (frame_count),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", tag, act, req);
    endtask

    function automatic logic [47:0] rep4(input logic [11:0] w);
        return {w, w, w, w};
    endfunction

    task automatic push_word(input logic [47:0] d, input logic s);
        word_t w;
        w.data = d;
        w.sync = s;
        exp_q.push_back(w);
    endtask

    // Expected per-lane word sequence; ul selects a line whose first ACTIVE
    // word is an underrun (zeros, no stream beats consumed), -1 for none.
    task automatic build_frame(input int ul);
        int bi;
        logic [31:0] b0, b1;
        bi = 0;
        for (int l = 0; l < NL; l++) begin
            push_word(rep4(12'hFFF), 1'b1);
            push_word(rep4(12'h000), 1'b1);
            push_word(rep4(12'h000), 1'b1);
            push_word(rep4((l == 0) ? 12'h003 : 12'h001), 1'b1);
            for (int w = 0; w < LW; w++) begin
                if (l == ul && w == 0) begin
                    push_word(48'h0, 1'b0);
                end else begin
                    b0 = frame_beats[bi];
                    b1 = frame_beats[bi + 1];
                    bi += 2;
                    push_word({b1[27:16], b1[11:0], b0[27:16], b0[11:0]}, 1'b0);
                end
            end
            push_word(rep4(12'hFFF), 1'b1);
            push_word(rep4(12'h000), 1'b1);
            push_word(rep4(12'h000), 1'b1);
            push_word(rep4((l == NL - 1) ? 12'h007 : 12'h005), 1'b1);
            if (l < NL - 1) for (int h = 0; h < HB; h++) push_word(48'h0, 1'b0);
        end
        for (int v = 0; v < VB; v++) push_word(48'h0, 1'b0);
    endtask

    task automatic drive_src(input logic allow);
        s_axis_tvalid = allow && (beat_q.size() > 0);
        s_axis_tdata  = (beat_q.size() > 0) ? beat_q[0] : 32'h0;
    endtask

    // Stream source bookkeeping at the handshake edge.
    always @(posedge clk) begin
        if (s_axis_tready) tready_seen = 1'b1;
        if (s_axis_tvalid && s_axis_tready) begin
            accepted++;
            if (beat_q.size() > 0) void'(beat_q.pop_front());
        end
    end

    // Output monitor: one expected word per tx_ce edge, hold otherwise.
    always @(posedge clk) begin
        ce_s = tx_ce;
        #1;
        if (mon_en) begin
            if (ce_s && exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                check("lane_data", 64'(lane_data), 64'(cur.data));
                check("lane_sync", 64'(lane_sync), 64'(cur.sync));
                last_exp = cur;
                has_last = 1'b1;
            end else if (has_last) begin
                check("lane_hold", 64'(lane_data), 64'(last_exp.data));
            end
        end
    end

    // mode 0: nominal (+ ignored start in ACTIVE), 1: underrun on first word,
    // 2: tx_ce one-in-three with random tvalid, 3: reset during line 1 ACTIVE.
    // Each ACTIVE word needs two beats, so modes 0/1/3 leave two strobe-free
    // cycles after the first ACTIVE word of each line for the pair to refill.
    task automatic run_frame(input int mode);
        int   words_issued;
        int   gap;
        logic ce;
        logic allow;
        logic got_done;
        words_issued = 0;
        gap          = 0;
        got_done     = 1'b0;
        accepted     = 0;
        has_last     = 1'b0;
        beat_q.delete();
        exp_q.delete();
        frame_beats[0] = 32'h0ABC0123;
        frame_beats[1] = 32'h04560789;
        for (int i = 2; i < NBEATS; i++) frame_beats[i] = $urandom;
        for (int i = 0; i < NBEATS; i++) beat_q.push_back(frame_beats[i]);
        for (int i = 0; i < 4; i++) beat_q.push_back($urandom);
        build_frame((mode == 1) ? 0 : -1);

        @(negedge clk);
        line_words = 12'(LW);
        num_lines  = 12'(NL);
        hblank     = 8'(HB);
        vblank     = 16'(VB);
        start      = 1'b1;
        tx_ce      = 1'b1;
        drive_src(mode != 1);
        @(negedge clk);
        start  = 1'b0;
        mon_en = 1'b1;

        for (int k = 1; k < 300; k++) begin
            ce    = 1'b1;
            allow = 1'b1;
            start = 1'b0;
            if (mode == 2) begin
                ce = (k % 3 == 0);
                if (ce) allow = 1'($urandom_range(0, 1));
            end else begin
                if (mode == 0 && words_issued == 5 && gap == 2) start = 1'b1;
                if (gap > 0) begin
                    ce = 1'b0;
                    gap--;
                end
                if (mode == 1) allow = (words_issued >= 5);
            end
            tx_ce = ce;
            drive_src(allow);
            @(negedge clk);
            if (ce) begin
                words_issued++;
                if (mode != 2 && (words_issued == 5 || words_issued == 18)) gap = 2;
            end
            if (mode == 3 && words_issued == 18) begin
                aresetn       = 1'b0;
                mon_en        = 1'b0;
                tx_ce         = 1'b0;
                s_axis_tvalid = 1'b0;
                #1;
                check("rst_lane_data", 64'(lane_data), 64'h0);
                check("rst_lane_sync", 64'(lane_sync), 64'h0);
                check("rst_busy", 64'(busy), 64'h0);
                check("rst_tready", 64'(s_axis_tready), 64'h0);
                check("rst_frame_count", 64'(frame_count), 64'h0);
                check("rst_done", 64'(done), 64'h0);
                exp_q.delete();
                beat_q.delete();
                repeat (2) @(negedge clk);
                aresetn = 1'b1;
                @(negedge clk);
                return;
            end
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        start         = 1'b0;
        tx_ce         = 1'b0;
        s_axis_tvalid = 1'b0;
        check("done_seen", 64'(got_done), 64'h1);
        check("words_left", 64'(exp_q.size()), 64'h0);
        check("busy_after_done", 64'(busy), 64'h0);
        @(negedge clk);
        check("done_width", 64'(done), 64'h0);
        mon_en = 1'b0;
    endtask

    initial begin
        aresetn       = 1'b0;
        tx_ce         = 1'b0;
        start         = 1'b0;
        line_words    = '0;
        num_lines     = '0;
        hblank        = '0;
        vblank        = '0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_lane_data", 64'(lane_data), 64'h0);
        check("reset_lane_sync", 64'(lane_sync), 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_done", 64'(done), 64'h0);
        check("reset_frame_count", 64'(frame_count), 64'h0);
        check("reset_underrun", 64'(underrun_count), 64'h0);
        check("reset_tready", 64'(s_axis_tready), 64'h0);
        aresetn = 1'b1;
        @(negedge clk);

        run_frame(0);
        check("nom_frame_count", 64'(frame_count), 64'h1);
        check("nom_underrun", 64'(underrun_count), 64'h0);
        check("nom_beats", 64'(accepted), 64'(NBEATS));
        repeat (3) @(negedge clk);
        check("nom_no_restart", 64'(busy), 64'h0);

        run_frame(1);
        check("ur_frame_count", 64'(frame_count), 64'h2);
        check("ur_underrun", 64'(underrun_count), 64'h1);
        check("ur_beats", 64'(accepted), 64'(NBEATS - 2));

        run_frame(2);
        check("slow_frame_count", 64'(frame_count), 64'h3);
        check("slow_underrun", 64'(underrun_count), 64'h0);
        check("slow_beats", 64'(accepted), 64'(NBEATS));

        beat_q.delete();
        for (int i = 0; i < 4; i++) beat_q.push_back($urandom);
        accepted    = 0;
        tready_seen = 1'b0;
        @(negedge clk);
        line_words = 12'd2;
        num_lines  = 12'd0;
        start      = 1'b1;
        drive_src(1'b1);
        @(negedge clk);
        start = 1'b0;
        check("zero_done", 64'(done), 64'h1);
        check("zero_busy", 64'(busy), 64'h0);
        @(negedge clk);
        check("zero_done_width", 64'(done), 64'h0);
        repeat (3) @(negedge clk);
        s_axis_tvalid = 1'b0;
        check("zero_tready", 64'(tready_seen), 64'h0);
        check("zero_beats", 64'(accepted), 64'h0);
        check("zero_frame_count", 64'(frame_count), 64'h3);

        run_frame(3);
        run_frame(0);
        check("post_rst_frame_count", 64'(frame_count), 64'h1);
        check("post_rst_underrun", 64'(underrun_count), 64'h0);
        check("post_rst_beats", 64'(accepted), 64'(NBEATS));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
